// File: rtl/chu_vga_multi_sprite_core.sv
// rtl/chu_vga_multi_sprite_core.sv - N-sprite overlay with per-sprite frame RAM, animation and collision
// Two-stage pixel pipeline: stage 1 issues RAM reads and window flags, stage 2 composites.
module chu_vga_multi_sprite_core #(
  parameter int CD         = 12,
  parameter int N_SPRITE   = 4,
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int N_FRAME    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int KEY_COLOR  = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          write,
  input  logic          read,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);
  localparam int SW = (N_SPRITE > 1) ? $clog2(N_SPRITE) : 1;
  localparam int FW = (N_FRAME > 1) ? $clog2(N_FRAME) : 1;
  localparam int WW = $clog2(SPR_W);
  localparam int HW = $clog2(SPR_H);
  localparam logic [CD-1:0] KEY     = CD'(KEY_COLOR);
  localparam logic [11:0]   SPR_W12 = 12'(SPR_W);
  localparam logic [11:0]   SPR_H12 = 12'(SPR_H);
  localparam logic [WW-1:0] COL_MAX = WW'(SPR_W - 1);

  logic          r_en    [N_SPRITE];
  logic [10:0]   r_x0    [N_SPRITE];
  logic [10:0]   r_y0    [N_SPRITE];
  logic [3:0]    r_ctrl  [N_SPRITE];
  logic [FW-1:0] r_frame [N_SPRITE];
  logic          r_bypass;
  logic [N_SPRITE-1:0] r_status;
  logic [7:0]    r_div;
  logic [7:0]    r_divcnt;
  logic          r_prev_at0;

  logic [CD-1:0] r_ram [N_SPRITE][2**ADDR_WIDTH];
  logic [CD-1:0] r_pix [N_SPRITE];
  logic [N_SPRITE-1:0] r_vis;
  logic [CD-1:0] r_si;
  logic          r_byp1;

  logic          w_ram_wr, w_reg_wr, w_at0, w_tick, w_step, w_div_wr;
  logic [SW-1:0] w_ram_spr, w_reg_spr;
  logic [2:0]    w_reg_idx;
  logic [N_SPRITE-1:0] w_clr, w_inside, w_opaque, w_coll_set;
  logic [11:0]   w_dx [N_SPRITE];
  logic [11:0]   w_dy [N_SPRITE];
  logic [WW-1:0] w_col [N_SPRITE];
  logic [ADDR_WIDTH-1:0] w_raddr [N_SPRITE];
  logic [CD-1:0] w_mix;
  logic          w_seen, w_multi;
  logic [31:0]   w_rd_val;
  logic          w_unused;

  assign w_ram_wr  = cs & write & ~addr[13];
  assign w_reg_wr  = cs & write & addr[13];
  assign w_ram_spr = addr[ADDR_WIDTH+SW-1:ADDR_WIDTH];
  assign w_reg_spr = addr[SW+2:3];
  assign w_reg_idx = addr[2:0];
  assign w_div_wr  = w_reg_wr && (w_reg_idx == 3'd6);
  assign w_clr     = (w_reg_wr && (w_reg_idx == 3'd5)) ? wr_data[N_SPRITE-1:0] : '0;
  assign w_unused  = ^{wr_data, addr};

  // Frame tick fires only on the first cycle of (0,0), so a held (0,0) counts once
  assign w_at0  = (x == 11'd0) && (y == 11'd0);
  assign w_tick = w_at0 & ~r_prev_at0;
  assign w_step = w_tick && (r_divcnt == r_div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < N_SPRITE; s++) begin
        r_en[s]    <= 1'b0;
        r_x0[s]    <= '0;
        r_y0[s]    <= '0;
        r_ctrl[s]  <= '0;
        r_frame[s] <= '0;
      end
      r_bypass   <= 1'b0;
      r_status   <= '0;
      r_div      <= '0;
      r_divcnt   <= '0;
      r_prev_at0 <= 1'b0;
    end else begin
      r_prev_at0 <= w_at0;
      if (w_div_wr)
        r_divcnt <= '0;
      else if (w_tick)
        r_divcnt <= w_step ? 8'd0 : r_divcnt + 8'd1;
      for (int s = 0; s < N_SPRITE; s++) begin
        if (w_step && r_ctrl[s][2])
          r_frame[s] <= r_frame[s] + 1'b1;
        // Later assignment wins: a ctrl write overrides a same-cycle animation step
        if (w_reg_wr && (w_reg_spr == SW'(s))) begin
          case (w_reg_idx)
            3'd0: r_en[s] <= wr_data[0];
            3'd1: r_x0[s] <= wr_data[10:0];
            3'd2: r_y0[s] <= wr_data[10:0];
            3'd3: begin
              r_ctrl[s]  <= wr_data[3:0];
              r_frame[s] <= FW'(wr_data[1:0]);
            end
            default: ;
          endcase
        end
      end
      if (w_reg_wr && (w_reg_idx == 3'd4)) r_bypass <= wr_data[0];
      if (w_div_wr) r_div <= wr_data[7:0];
      r_status <= (r_status & ~w_clr) | w_coll_set;
    end
  end

  always_comb begin
    for (int s = 0; s < N_SPRITE; s++) begin
      w_dx[s]     = {1'b0, x} - {1'b0, r_x0[s]};
      w_dy[s]     = {1'b0, y} - {1'b0, r_y0[s]};
      w_inside[s] = ~w_dx[s][11] && (w_dx[s] < SPR_W12) && ~w_dy[s][11] && (w_dy[s] < SPR_H12);
      w_col[s]    = r_ctrl[s][3] ? (COL_MAX - w_dx[s][WW-1:0]) : w_dx[s][WW-1:0];
      w_raddr[s]  = {r_frame[s], w_dy[s][HW-1:0], w_col[s]};
    end
  end

  // Read-before-write: a display read of a word being written sees the old pixel
  always_ff @(posedge clk) begin
    for (int s = 0; s < N_SPRITE; s++) begin
      if (w_ram_wr && (w_ram_spr == SW'(s)))
        r_ram[s][addr[ADDR_WIDTH-1:0]] <= wr_data[CD-1:0];
      r_pix[s] <= r_ram[s][w_raddr[s]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vis  <= '0;
      r_si   <= '0;
      r_byp1 <= 1'b0;
      so_rgb <= '0;
    end else begin
      for (int s = 0; s < N_SPRITE; s++)
        r_vis[s] <= r_en[s] & w_inside[s];
      r_si   <= si_rgb;
      r_byp1 <= r_bypass;
      so_rgb <= r_byp1 ? r_si : w_mix;
    end
  end

  always_comb begin
    w_mix    = r_si;
    w_seen   = 1'b0;
    w_multi  = 1'b0;
    w_opaque = '0;
    for (int s = N_SPRITE - 1; s >= 0; s--) begin
      w_opaque[s] = r_vis[s] && (r_pix[s] != KEY);
      if (w_opaque[s]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
        w_mix  = r_pix[s];
      end
    end
  end

  assign w_coll_set = w_multi ? w_opaque : '0;

  always_comb begin
    w_rd_val = '0;
    if (addr[13]) begin
      case (w_reg_idx)
        3'd4: w_rd_val = {31'd0, r_bypass};
        3'd5: w_rd_val = 32'(r_status);
        3'd6: w_rd_val = {24'd0, r_div};
        3'd7: w_rd_val = '0;
        default: begin
          for (int s = 0; s < N_SPRITE; s++) begin
            if (w_reg_spr == SW'(s)) begin
              case (w_reg_idx)
                3'd0:    w_rd_val = {31'd0, r_en[s]};
                3'd1:    w_rd_val = {21'd0, r_x0[s]};
                3'd2:    w_rd_val = {21'd0, r_y0[s]};
                default: w_rd_val = {28'd0, r_ctrl[s]};
              endcase
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rd_data <= '0;
    else if (cs & read)
      rd_data <= w_rd_val;
  end
endmodule

// File: tb/tb_chu_vga_multi_sprite_core.sv
// tb/tb_chu_vga_multi_sprite_core.sv - scoreboard bench for chu_vga_multi_sprite_core
module tb_chu_vga_multi_sprite_core;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x, y;
  logic        cs, write, read;
  logic [13:0] addr;
  logic [31:0] wr_data, rd_data;
  logic [11:0] si_rgb, so_rgb;

  always #5 clk = ~clk;

  chu_vga_multi_sprite_core dut (
    .clk(clk), .reset_n(reset_n), .x(x), .y(y), .cs(cs), .write(write), .read(read),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .si_rgb(si_rgb), .so_rgb(so_rgb)
  );

  typedef struct {
    int          due;
    logic        chk;
    logic [11:0] exp;
    int          id;
  } pix_t;

  pix_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pid     = 0;
  int mcnt, mframe;
  logic manim;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      pix_t e;
      e = sb_q.pop_front();
      if (e.chk) begin
        n_tests++;
        if (e.due != cyc || so_rgb !== e.exp) begin
          n_fail++;
          $display("FAIL pix%0d so_rgb got %h expected %h (due %0d now %0d)", e.id, so_rgb, e.exp, e.due, cyc);
        end
      end
    end
  end

  function automatic logic [13:0] ra(input int s, input int f, input int r, input int c);
    return 14'(s * 1024 + f * 256 + r * 16 + c);
  endfunction

  function automatic logic [13:0] rg(input int s, input int i);
    return 14'(8192 + s * 8 + i);
  endfunction

  task automatic px(input int xi, input int yi, input logic [11:0] si, input logic chk, input logic [11:0] exp);
    pix_t e;
    @(negedge clk);
    x = 11'(xi); y = 11'(yi); si_rgb = si;
    e.due = cyc + 2; e.chk = chk; e.exp = exp; e.id = pid;
    pid++;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    px(1500, 1000, 12'h000, 1'b0, 12'h000);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk);
    #1 cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    @(posedge clk);
    #1 cs = 1'b0; read = 1'b0;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb_q.size() > 0 && i < 20) begin
      @(negedge clk);
      i++;
    end
    if (sb_q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain queue size %0d expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic chk_rd(input logic [13:0] a, input logic [31:0] exp, input int tag);
    logic [31:0] d;
    rd(a, d);
    n_tests++;
    if (d !== exp) begin
      n_fail++;
      $display("FAIL rd%0d addr %h got %h expected %h", tag, a, d, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cs = 1'b0; write = 1'b0; read = 1'b0; addr = '0; wr_data = '0;
    x = 11'd1500; y = 11'd1000; si_rgb = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (so_rgb !== 12'h000) begin n_fail++; $display("FAIL reset_so got %h expected 000", so_rgb); end
    n_tests++;
    if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd got %h expected 0", rd_data); end
    @(negedge clk);
    reset_n = 1'b1;
    chk_rd(rg(0, 1), 32'h0, 1);
    chk_rd(rg(2, 3), 32'h0, 2);
    chk_rd(rg(0, 5), 32'h0, 3);
    chk_rd(rg(0, 6), 32'h0, 4);
    // RAM is not reset; flood it with the key colour so every window reads defined pixels
    for (int w = 0; w < 4096; w++) wr(14'(w), 32'h0);
  endtask

  task automatic test_basic();
    wr(ra(0, 0, 0, 0), 32'hF00);
    wr(rg(0, 1), 100);
    wr(rg(0, 2), 50);
    wr(rg(0, 0), 1);
    px(100, 50, 12'h0AA, 1'b1, 12'hF00);
    px(101, 50, 12'h0AA, 1'b1, 12'h0AA);
    px(99, 50, 12'h123, 1'b1, 12'h123);
    px(100, 66, 12'h124, 1'b1, 12'h124);
    idle();
    drain();
  endtask

  task automatic test_priority();
    wr(ra(1, 0, 0, 0), 32'h0F0);
    wr(rg(0, 1), 10); wr(rg(0, 2), 10);
    wr(rg(1, 1), 10); wr(rg(1, 2), 10);
    wr(rg(1, 0), 1);
    px(10, 10, 12'h555, 1'b1, 12'hF00);
    px(11, 10, 12'h555, 1'b1, 12'h555);
    idle();
    drain();
    chk_rd(rg(0, 5), 32'h3, 10);
    wr(rg(0, 5), 32'h1);
    chk_rd(rg(0, 5), 32'h2, 11);
    wr(rg(0, 0), 0);
    px(10, 10, 12'h555, 1'b1, 12'h0F0);
    idle();
    drain();
    wr(rg(0, 5), 32'hF);
    chk_rd(rg(0, 5), 32'h0, 12);
    wr(rg(0, 0), 1);
  endtask

  task automatic test_bypass();
    wr(rg(3, 4), 1);
    chk_rd(rg(0, 4), 32'h1, 20);
    px(10, 10, 12'h777, 1'b1, 12'h777);
    idle();
    drain();
    chk_rd(rg(0, 5), 32'h3, 21);
    wr(rg(0, 5), 32'h3);
    wr(rg(0, 4), 0);
    px(10, 10, 12'h777, 1'b1, 12'hF00);
    idle();
    drain();
    wr(rg(0, 5), 32'h3);
    chk_rd(rg(0, 5), 32'h0, 22);
  endtask

  task automatic test_edge();
    for (int c = 0; c < 8; c++) wr(ra(2, 0, 0, c), 32'(12'h800 + c));
    wr(rg(2, 1), 2040); wr(rg(2, 2), 200); wr(rg(2, 0), 1);
    px(2047, 200, 12'h111, 1'b1, 12'h807);
    px(2040, 200, 12'h111, 1'b1, 12'h800);
    for (int c = 0; c < 8; c++) px(c, 200, 12'h111, 1'b1, 12'h111);
    wr(ra(3, 0, 0, 15), 32'h0F1);
    wr(ra(3, 0, 0, 0), 32'h0F2);
    wr(rg(3, 1), 300); wr(rg(3, 2), 300); wr(rg(3, 3), 8); wr(rg(3, 0), 1);
    px(300, 300, 12'h222, 1'b1, 12'h0F1);
    px(315, 300, 12'h222, 1'b1, 12'h0F2);
    idle();
    drain();
  endtask

  task automatic model_tick(input logic ctrl_wr, input logic [1:0] ctrl_frame);
    if (mcnt == 2) begin
      mcnt = 0;
      if (manim) mframe = (mframe + 1) % 4;
    end else begin
      mcnt++;
    end
    if (ctrl_wr) mframe = ctrl_frame;
  endtask

  task automatic tick_probe();
    px(0, 0, 12'h0AA, 1'b1, 12'h0AA);
    model_tick(1'b0, 2'd0);
    px(300, 300, 12'h0AA, 1'b1, 12'(12'h310 + mframe));
    idle();
  endtask

  task automatic test_anim();
    pix_t e;
    for (int f = 0; f < 4; f++) wr(ra(3, f, 0, 0), 32'(12'h310 + f));
    wr(rg(3, 3), 7);
    wr(rg(0, 6), 2);
    mcnt = 0; mframe = 3; manim = 1'b1;
    px(300, 300, 12'h0AA, 1'b1, 12'h313);
    idle();
    for (int t = 0; t < 8; t++) tick_probe();
    // tick whose divider step coincides with a ctrl write: the write's frame must win
    @(negedge clk);
    x = 11'd0; y = 11'd0; si_rgb = 12'h0AA;
    cs = 1'b1; write = 1'b1; addr = rg(3, 3); wr_data = 32'h4;
    e.due = cyc + 2; e.chk = 1'b1; e.exp = 12'h0AA; e.id = pid;
    pid++;
    sb_q.push_back(e);
    @(posedge clk);
    #1 cs = 1'b0; write = 1'b0;
    model_tick(1'b1, 2'd0);
    px(300, 300, 12'h0AA, 1'b1, 12'(12'h310 + mframe));
    idle();
    wr(rg(3, 3), 1);
    manim = 1'b0; mframe = 1;
    for (int t = 0; t < 3; t++) tick_probe();
    drain();
  endtask

  task automatic test_readback();
    wr(rg(1, 1), 32'h7FF);
    chk_rd(rg(1, 1), 32'h7FF, 30);
    repeat (3) @(negedge clk);
    n_tests++;
    if (rd_data !== 32'h7FF) begin n_fail++; $display("FAIL rd_hold got %h expected 7ff", rd_data); end
    chk_rd(rg(0, 7), 32'h0, 31);
    chk_rd(ra(0, 0, 0, 0), 32'h0, 32);
    chk_rd(rg(3, 3), 32'h1, 33);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    px(10, 10, 12'h321, 1'b0, 12'h000);
    drain();
    repeat (3) @(negedge clk);
    n_tests++;
    if (so_rgb !== 12'hF00) begin n_fail++; $display("FAIL pre_reset_so got %h expected f00", so_rgb); end
    rd(rg(1, 1), d);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (so_rgb !== 12'h000) begin n_fail++; $display("FAIL mid_reset_so got %h expected 000", so_rgb); end
    n_tests++;
    if (rd_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rd got %h expected 0", rd_data); end
    @(negedge clk);
    reset_n = 1'b1;
    chk_rd(rg(1, 1), 32'h0, 40);
    chk_rd(rg(0, 0), 32'h0, 41);
    chk_rd(rg(0, 6), 32'h0, 42);
    px(10, 10, 12'h321, 1'b1, 12'h321);
    idle();
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_bypass();
    test_edge();
    test_anim();
    test_readback();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/chu_vga_multi_sprite_core.md
# chu_vga_multi_sprite_core

Parametrised multi-sprite overlay core for the VGA stream pipeline: N independent sprites, each with its own pixel RAM holding several animation frames, position, control and mirror settings, composited over the incoming stream with fixed priority and chroma-key transparency. It adds hardware frame-timed animation, sprite-to-sprite collision detection and a register read-back path. It sits in a video slot between the upstream stream source and the next overlay stage, driven by the shared frame counter.

## Interface
- CD, 12, colour depth in bits
- N_SPRITE, 4, number of sprites (power of 2, 1..8); SW = log2(N_SPRITE), minimum 1
- SPR_W, 16, sprite width in pixels (power of 2)
- SPR_H, 16, sprite height in pixels (power of 2)
- N_FRAME, 4, animation frames per sprite (power of 2)
- ADDR_WIDTH, 10, per-sprite RAM address width = log2(SPR_W*SPR_H*N_FRAME)
- KEY_COLOR, 0, transparent colour value

- clk  in  1  system clock; all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- x, y  in  11 each  current pixel coordinate from the frame counter
- cs  in  1  slot select
- write  in  1  write strobe, qualified by cs
- read  in  1  read strobe, qualified by cs
- addr  in  14  slot word address
- wr_data  in  32  write data
- rd_data  out  32  registered read data
- si_rgb  in  CD  upstream pixel, aligned with x and y
- so_rgb  out  CD  composited pixel, registered

## Operation
- Address decode:
  - addr[13]=0 is a pixel RAM write. addr[ADDR_WIDTH+SW-1:ADDR_WIDTH] selects the sprite, addr[ADDR_WIDTH-1:0] selects the word, wr_data[CD-1:0] is the pixel.
  - Word index = frame*SPR_W*SPR_H + row*SPR_W + col.
  - addr[13]=1 is a register access. addr[SW+2:3] selects the sprite and addr[2:0] selects the register.
- Registers, with reset values:
  - 0: enable[0], 0
  - 1: x0[10:0], 0
  - 2: y0[10:0], 0
  - 3: ctrl[3:0], 0. Bits [1:0] are the static frame, bit 2 is animate, bit 3 is horizontal mirror.
  - 4: global bypass[0], 0. The sprite index is ignored.
  - 5: collision status[N_SPRITE-1:0], 0, global. Writing 1 to a bit clears it.
  - 6: animation divisor div[7:0], 0, global.
  - Register reads return the value zero-extended. Reads of RAM and of undefined registers return 0.
- Sprite hit test:
  - dx = {1'b0,x} - {1'b0,x0} and dy is formed the same way, both 12-bit.
  - A sprite is inside its window when dx[11]=0, dx<SPR_W, dy[11]=0 and dy<SPR_H. This clips at the screen edges and never wraps.
  - col = mirror ? SPR_W-1-dx : dx.
- Compositing:
  - A sprite is opaque when it is enabled, inside its window and its RAM pixel != KEY_COLOR.
  - The lowest-index opaque sprite wins. With no opaque sprite the output is si_rgb.
  - When bypass=1, so_rgb = si_rgb.
- Collision: when two or more sprites are opaque at the same pixel, each involved sprite's status bit is set (sticky). This happens regardless of bypass.
- Animation:
  - A frame tick occurs on the cycle where (x,y)=(0,0) and the previous cycle's (x,y) was not (0,0).
  - An 8-bit divider counts ticks. When it equals div, it clears and an animation step fires. With div=0, every tick steps.
  - On a step, every sprite with animate=1 advances its frame index modulo N_FRAME.
  - Writing ctrl loads the frame index from ctrl[1:0]. When animate=0, the frame index stays at ctrl[1:0].
  - A step and a ctrl write to the same sprite in the same cycle resolve to the ctrl write.
  - Writing div clears the divider.
- Simultaneous events:
  - A collision set and a clear of the same bit in one cycle resolve to set.
  - A RAM write and a display read of the same word in one cycle return the old data on the display path.

## Timing
- Pixel pipeline has 2 stages.
  - Stage 1 registers the RAM addresses, per-sprite in-window and enable flags, and si_rgb.
  - Stage 2 takes the synchronous RAM output, composites it and registers the result into so_rgb.
  - Latency from x, y, si_rgb to so_rgb is exactly 2 cycles.
- Collision status updates at the end of stage 2 and is visible to a read 1 cycle later.
- Register writes take effect on the next clock edge. A pixel already in the pipeline uses the old values.
- rd_data is valid the cycle after cs&read and holds its value until the next read.
- Asynchronous reset clears so_rgb, rd_data, all registers, frame indices, the divider and the pipeline to 0. Deasserting reset mid-frame resumes compositing from the next valid (x,y).
- RAM contents are not reset.

## Test plan
- RAM write with sprite 0 at (100,50), enable=1, pixel at frame 0 row 0 col 0 = 0xF00 → (x,y)=(100,50) gives so_rgb=0xF00 two cycles later. (101,50) with a key pixel passes si_rgb=0x0AA through.
- Sprites 0 and 1 overlap at (10,10), both opaque, 0xF00 and 0x0F0 → so_rgb=0xF00 and status reads 0x3. Writing 0x1 to register 5 leaves the status at 0x2.
- Sprite at x0=2040 with SPR_W=16: x=2047 is drawn, x=0..7 on the same line is not drawn (no wrap). mirror=1 at dx=0 fetches col 15.
- div=2, animate=1, static frame 3 → frame index 3,0,1 after 3 and 6 frame ticks. A ctrl write in the step cycle yields ctrl[1:0].
- bypass=1 → so_rgb=si_rgb while status still sets on overlap. A reset_n pulse mid-line drives so_rgb, rd_data and all registers to 0 immediately.
- Read of x0 after writing 0x7FF returns 0x000007FF one cycle after the read strobe. A read of register 7 returns 0.
